// File: rtl/serial_word_alu.sv
// Bit-serial add/subtract engine: latches two N-bit words, streams them LSB-first
// through a single carry/borrow bit, and reassembles the result word.
module serial_word_alu #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         ser_vld,
  output logic         ser_x,
  output logic         ser_y,
  output logic         ser_s
);
  // state   | meaning
  // S_IDLE  | waiting for start; operands latched on accept
  // S_SHIFT | one bit per clk, N cycles, LSB first
  // S_DONE  | one-cycle done pulse, result and cout valid
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_sha;
  logic [N-1:0]  r_shb;
  logic [N-1:0]  r_res;
  logic [CW-1:0] r_cnt;
  logic          r_c;
  logic          r_mode;
  logic          r_cout;
  logic          w_ye;
  logic          w_s;
  logic          w_c_nxt;
  logic          w_last;

  // Subtraction is A + ~B + 1: invert the B bit, carry-in primed with 1 on accept.
  assign w_ye    = r_shb[0] ^ r_mode;
  assign w_s     = r_sha[0] ^ w_ye ^ r_c;
  assign w_c_nxt = (r_sha[0] & w_ye) | (r_sha[0] & r_c) | (w_ye & r_c);
  assign w_last  = (r_cnt == LAST);

  assign result = r_res;
  assign cout   = r_cout;
  assign ser_x  = r_sha[0];
  assign ser_y  = r_shb[0];
  assign ser_s  = w_s;

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    ser_vld     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        busy    = 1'b1;
        ser_vld = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
      r_sha   <= '0;
      r_shb   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_mode  <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sha  <= a;
            r_shb  <= b;
            r_mode <= sub;
            r_c    <= sub;
            r_cnt  <= '0;
          end
        end
        S_SHIFT: begin
          r_c   <= w_c_nxt;
          r_res <= {w_s, r_res[N-1:1]};
          r_sha <= {1'b0, r_sha[N-1:1]};
          r_shb <= {1'b0, r_shb[N-1:1]};
          // Borrow is the complement of the final carry in subtract mode.
          if (w_last) r_cout <= w_c_nxt ^ r_mode;
          else        r_cnt  <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_word_alu.sv
// Self-checking bench for serial_word_alu: arithmetic reference model checked
// every cycle, plus literal expectations for the directed cases.
module tb_serial_word_alu;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done, cout, ser_vld, ser_x, ser_y, ser_s;
  logic [N-1:0] result;

  serial_word_alu #(.N(N)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .ser_vld(ser_vld), .ser_x(ser_x), .ser_y(ser_y), .ser_s(ser_s)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Unsigned modulo-2^N arithmetic; top bit is carry (add) or borrow (sub).
  function automatic logic [N:0] ref_op(input logic [N-1:0] x, input logic [N-1:0] y,
                                        input logic s);
    logic [N:0] r;
    if (s) begin
      r[N-1:0] = x - y;
      r[N]     = (x < y);
    end else begin
      r = {1'b0, x} + {1'b0, y};
    end
    return r;
  endfunction

  // Model: m_phase counts cycles since accept (0 idle, 1..N shift, N+1 done).
  int           m_phase = 0;
  logic [N-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic         m_cout = 1'b0;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_phase <= 0;
      m_a     <= '0;
      m_b     <= '0;
      m_res   <= '0;
      m_cout  <= 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase <= 1;
        m_a     <= a;
        m_b     <= b;
        {m_cout, m_res} <= ref_op(a, b, sub);
      end
    end else if (m_phase == N + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  logic [N-1:0] cap_s = '0, cap_y = '0;
  int           vld_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      chk("busy", busy, (m_phase != 0));
      chk("done", done, (m_phase == N + 1));
      chk("ser_vld", ser_vld, (m_phase >= 1 && m_phase <= N));
      if (m_phase >= 1 && m_phase <= N) begin
        chk("ser_x", ser_x, m_a[m_phase-1]);
        chk("ser_y", ser_y, m_b[m_phase-1]);
        chk("ser_s", ser_s, m_res[m_phase-1]);
        cap_s = {ser_s, cap_s[N-1:1]};
        cap_y = {ser_y, cap_y[N-1:1]};
        vld_cnt++;
      end else if (m_phase == 0) begin
        vld_cnt = 0;
      end
      if (m_phase == 0 || m_phase == N + 1) begin
        chk("result", result, m_res);
        chk("cout", cout, m_cout);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  // Accept at the next edge, then scramble inputs to prove they were latched.
  task automatic launch(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    a = x; b = y; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    a = N'($urandom); b = N'($urandom); sub = 1'($urandom);
  endtask

  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                        output int lat);
    launch(x, y, s);
    wait_done(lat);
  endtask

  initial begin
    int lat;
    logic [N:0] r;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ser_vld", ser_vld, 0);
    chk("rst_ser_xys", {ser_x, ser_y, ser_s}, 0);
    #11 rst_b = 1'b1;
    tick();

    // 1: 0x35 + 0x1C
    launch(8'h35, 8'h1C, 1'b0);
    chk("t1_busy_rise", busy, 1);
    wait_done(lat);
    chk("t1_latency", lat + 1, N + 1);
    chk("t1_result", result, 8'h51);
    chk("t1_cout", cout, 0);
    chk("t1_ser_s_stream", cap_s, 8'h51);
    tick();

    // 2: 0xFF + 0x01 wraps with carry
    run_op(8'hFF, 8'h01, 1'b0, lat);
    chk("t2_result", result, 8'h00);
    chk("t2_cout", cout, 1);
    chk("t2_ser_s_stream", cap_s, 8'h00);
    chk("t2_vld_cycles", vld_cnt, N);
    tick();

    // 3: 0x50 - 0x21, raw b on ser_y
    run_op(8'h50, 8'h21, 1'b1, lat);
    chk("t3_result", result, 8'h2F);
    chk("t3_cout", cout, 0);
    chk("t3_ser_y_stream", cap_y, 8'h21);
    tick();

    // 4: equal operands, then borrow case
    run_op(8'h7A, 8'h7A, 1'b1, lat);
    chk("t4b_result", result, 8'h00);
    chk("t4b_cout", cout, 0);
    tick();
    run_op(8'h03, 8'h05, 1'b1, lat);
    chk("t4a_result", result, 8'hFE);
    chk("t4a_cout", cout, 1);
    tick();

    // 5: start ignored in SHIFT and DONE, accepted once back in IDLE
    launch(8'h12, 8'h34, 1'b0);
    tick(); tick();
    a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    chk("t5_first_result", result, 8'h46);
    a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
    tick();
    chk("t5_idle_busy", busy, 0);
    chk("t5_result_intact", result, 8'h46);
    tick();
    start = 1'b0;
    chk("t5_accepted", busy, 1);
    wait_done(lat);
    chk("t5_second_result", result, 8'h33);
    tick();

    // 6: asynchronous reset during bit 4 of a shift
    launch(8'h35, 8'h1C, 1'b0);
    repeat (4) tick();
    #3 rst_b = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_result", result, 0);
    chk("t6_cout", cout, 0);
    chk("t6_ser_vld", ser_vld, 0);
    chk("t6_ser_xys", {ser_x, ser_y, ser_s}, 0);
    @(posedge clk);
    #3 rst_b = 1'b1;
    repeat (N + 4) begin
      tick();
      chk("t6_no_done", done, 0);
    end
    run_op(8'h0F, 8'h01, 1'b0, lat);
    chk("t6_result_after", result, 8'h10);
    chk("t6_cout_after", cout, 0);
    tick();

    // Random operations with random gaps, including back-to-back
    for (int i = 0; i < 60; i++) begin
      logic [N-1:0] x, y;
      logic s;
      x = N'($urandom); y = N'($urandom); s = 1'($urandom);
      if (i % 10 == 0) y = x;
      r = ref_op(x, y, s);
      run_op(x, y, s, lat);
      chk("rand_latency", lat + 1, N + 1);
      chk("rand_result", result, r[N-1:0]);
      chk("rand_cout", cout, r[N]);
      repeat ($urandom_range(1, 4)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_word_alu.md
Name: serial_word_alu

Overview:
- Bit-serial add/subtract engine with a parallel operand/result handshake.
- Loads two N-bit words, streams them LSB-first through a one-bit carry/borrow state machine, one bit per clk, and reassembles the result word.
- Provides the transmit/collect side of the bit-serial adder datapath, plus subtraction as the inverse operation.
- Exposes the serial bit streams for monitoring and bench cross-checking.

Parameters:
- N, 8, operand/result width in bits; legal range N >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_b  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = a+b, 1 = a-b; latched with start
- a  input  N  operand A; latched with start
- b  input  N  operand B; latched with start
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse: result and cout valid
- result  output  N  sum/difference, modulo 2^N
- cout  output  1  add: carry out; sub: borrow out (1 when a < b, unsigned)
- ser_vld  output  1  high in SHIFT: ser_x, ser_y and ser_s carry a valid bit
- ser_x  output  1  current LSB of the A shift register
- ser_y  output  1  current LSB of the B shift register (not inverted)
- ser_s  output  1  current serial sum/difference bit

Behaviour:
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
  - State register is asynchronous-reset; next state and serial outputs are combinational.
- IDLE:
  - busy=0.
  - On start=1 at a rising edge: latch a into sha, b into shb, sub into mode.
  - Carry register c <= sub (carry-in 1 for subtraction). Bit counter cnt <= 0. Go to SHIFT.
- SHIFT (exactly N cycles):
  - Effective y bit ye = shb[0] XOR mode.
  - ser_s = sha[0] ^ ye ^ c. ser_x = sha[0]. ser_y = shb[0].
  - Each edge:
    - c <= majority(sha[0], ye, c).
    - result shifts right, with ser_s inserted at the MSB.
    - sha and shb shift right.
    - cnt increments.
  - At the edge where cnt == N-1, go to DONE.
- DONE (1 cycle):
  - done=1.
  - cout = c when mode=0, ~c when mode=1; registered at the DONE entry edge.
  - Go to IDLE at the next edge.
- Latency:
  - start sampled at edge E.
  - SHIFT occupies cycles E+1 .. E+N.
  - done=1 in cycle E+N+1.
  - Next start accepted from cycle E+N+2, so back-to-back throughput is one operation per N+2 cycles.
- Result hold:
  - result and cout hold until the next accepted start.
  - result shows partial bits during SHIFT; it is valid only while done=1 or after done, until the next start.
- start outside IDLE (SHIFT or DONE) is ignored; there is no queuing.
- Changes on a, b and sub after the accept edge have no effect.
- Reset (rst_b low at any time, including mid-SHIFT):
  - Immediately: state=IDLE and sha, shb, result, c, cnt, mode, cout = 0.
  - Hence busy=0, done=0, ser_vld=0, ser_x=ser_y=0.
  - ser_s=0, because mode=0 and c=0.
  - An aborted operation never produces a done pulse.
- Arithmetic:
  - Unsigned, modulo 2^N.
  - Subtraction is A + ~B + 1; borrow = ~carry.
- cnt width: ceil(log2(N)) bits, with no wrap beyond N-1.

Test Plan:
1. N=8, sub=0, a=0x35, b=0x1C, start pulsed -> busy rises next cycle; ser_s stream LSB-first 1,0,0,0,1,0,1,0; done in cycle E+9; result=0x51, cout=0.
2. sub=0, a=0xFF, b=0x01 -> result=0x00, cout=1; ser_s=0 on all 8 bits; ser_vld high exactly 8 cycles.
3. sub=1, a=0x50, b=0x21 -> result=0x2F, cout=0; ser_y shows raw b bits 1,0,0,0,0,1,0,0.
4. sub=1, a=0x03, b=0x05 -> result=0xFE, cout=1 (borrow); a=b=0x7A with sub=1 -> result=0x00, cout=0.
5. start held high with new operands (0x11, 0x22) during cycles E+3 and E+N+1 -> both ignored, first result intact.
   - start in cycle E+N+2 -> accepted; result=0x33 after N+1 further cycles.
6. rst_b low for one cycle during SHIFT bit 4, asynchronous to clk:
   - Immediately busy=0, result=0, cout=0, ser_vld=0, and no done pulse follows.
   - A fresh op 0x0F+0x01 then returns result=0x10, cout=0.
